clk12_set_ctrl: RTL and testbench
=================================

# clk12_set_ctrl

Controller that sequences and configures a 12-hour timekeeping datapath built around a loadable mod-12 hour counter plus a mod-60 minute counter. It advances time from a tick enable, and runs a three-state set-mode FSM driven by mode/inc button pulses. It also accepts an external parallel preset. It sits between the button/debounce logic and the display driver.

## Interface
- TICKS_PER_MIN, default 60: tick pulses per minute increment; legal range 2..1024.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz strobe)
- mode  in  1  one-cycle pulse, advances set-mode FSM
- inc  in  1  one-cycle pulse, increments field being set
- load  in  1  one-cycle preset strobe
- load_hr  in  4  preset hours value, 0..11
- load_min  in  6  preset minutes value, 0..59
- load_pm  in  1  preset PM flag
- hours  out  4  current hours 0..11; 0 means "12" to the display
- minutes  out  6  current minutes 0..59
- pm  out  1  AM(0)/PM(1)
- state  out  2  FSM state: RUN=0, SET_HR=1, SET_MIN=2

## Operation
- Reset values: hours=0, minutes=0, pm=0, state=RUN, prescaler=0.
- Event priority per cycle: rst > load > mode > inc/tick.
- **FSM transitions on mode:**
  - RUN -> SET_HR -> SET_MIN -> RUN.
  - Encoding 3 is illegal and returns to RUN on the next edge.
- **RUN:**
  - Each tick increments the prescaler 0..TICKS_PER_MIN-1.
  - A tick with prescaler==TICKS_PER_MIN-1 wraps the prescaler to 0 and increments minutes.
  - Minutes 59->0 increments hours.
  - Hours 11->0 toggles pm.
  - A full cascade (11:59 PM -> 0:00 AM) completes on one edge.
  - inc is ignored.
- **SET_HR:**
  - inc increments hours mod 12; an 11->0 wrap toggles pm.
  - tick is ignored; prescaler is held.
- **SET_MIN:**
  - inc increments minutes mod 60; no carry into hours.
  - tick is ignored.
- **Exit from SET_MIN:** the transition to RUN clears the prescaler to 0, so the first minute after setting is full length.
- **mode with inc or tick in the same cycle:** mode wins; inc and tick are dropped for that cycle.
- **load in any state:**
  - Sets hours, minutes, pm from the preset ports.
  - Forces state=RUN and prescaler=0.
  - Concurrent mode, inc and tick are dropped.
- **Out-of-range presets:** load_hr>11 loads hours=0; load_min>59 loads minutes=0.
- **Held inputs:** mode and inc held high count as one event per cycle. Debounce and edge detection are outside this block.

## Timing
- All outputs registered; no combinational input->output path.
- Latency: an outcome caused by an event in cycle N is visible on outputs after edge N+1.
- Reset mid-operation (any state, mid-cascade or mid-load) restores the reset values on that edge.
- Minute/hour/pm carries use the pre-edge values, so there is no one-cycle glitch state such as 11:00 with minutes wrapped but hours not yet advanced.

## Structure
- **Shared package:**
  - State encoding constants (RUN, SET_HR, SET_MIN).
  - HR_MAX=11 and MIN_MAX=59.
  - Port widths HR_W=4 and MIN_W=6.
- **Sub-module mod12_cnt_en:** 4-bit loadable mod-12 counter.
  - Ports: clk, rst, en, ld, din, q, wrap.
  - wrap = en & (q==11), combinational.
  - Priority: rst > ld > en.
  - ld with din>11 loads 0.
  - Instantiated once for hours.
- **Controller body:** minutes counter, prescaler, pm toggle and FSM live in the controller itself.

## Test plan
- **Reset and run:** assert rst, then run with TICKS_PER_MIN=4 and 4 ticks -> hours=0, minutes=1, pm=0, state=0.
- **Full cascade:** load 11/59/pm=0, then 4 ticks in RUN -> after the 4th tick's edge hours=0, minutes=0, pm=1, all on the same edge.
- **Set-hours path:**
  - mode once -> state=1.
  - 13 inc pulses from hours=0 -> hours=1, pm toggled once.
  - ticks during SET_HR leave minutes unchanged.
- **Set-minutes path and prescaler clear:**
  - mode into SET_MIN; 61 incs from minutes=0 -> minutes=1, hours unchanged.
  - mode -> state=0, prescaler=0, so the first minute increment needs exactly 4 ticks.
- **Simultaneous events:**
  - mode+inc in SET_HR -> state=2, hours unchanged.
  - load(5,30,1) with mode+tick -> 5:30 PM, state=0.
  - load_hr=14 -> hours=0.
- **Reset mid-set:** rst asserted while in SET_MIN at 7:45 -> next edge 0:00, pm=0, state=0; the next 4 ticks advance minutes to 1.

Source files
------------

// File: rtl/clk12_set_ctrl_pkg.sv
// Shared definitions for the 12-hour clock controller: state encoding,
// field limits and field widths.
package clk12_set_ctrl_pkg;

    localparam int HR_W  = 4;
    localparam int MIN_W = 6;

    localparam logic [HR_W-1:0]  HR_MAX  = 4'd11;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/clk12_set_ctrl_mod12_cnt_en.sv
// Loadable mod-12 counter; wrap flags the enabled 11->0 step so the caller
// can carry into the next field on the same edge.
module mod12_cnt_en
    import clk12_set_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            ld,
    input  logic [HR_W-1:0] din,
    output logic [HR_W-1:0] q,
    output logic            wrap
);

    logic [HR_W-1:0] cnt_q;
    logic [HR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = (din > HR_MAX) ? '0 : din;
        end else if (en) begin
            cnt_d = (cnt_q == HR_MAX) ? '0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q    = cnt_q;
    assign wrap = en & (cnt_q == HR_MAX);

endmodule

// File: rtl/clk12_set_ctrl.sv
// 12-hour timekeeping controller: tick-driven run mode, button-driven
// set-mode FSM and parallel preset, all outputs registered.
module clk12_set_ctrl
    import clk12_set_ctrl_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             mode,
    input  logic             inc,
    input  logic             load,
    input  logic [HR_W-1:0]  load_hr,
    input  logic [MIN_W-1:0] load_min,
    input  logic             load_pm,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic             pm,
    output logic [1:0]       state
);

    localparam int PW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MIN - 1);

    ctrl_state_e      state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             pm_q, pm_d;
    logic             hr_en;
    logic             hr_wrap;

    mod12_cnt_en u_hours (
        .clk  (clk),
        .rst  (rst),
        .en   (hr_en),
        .ld   (load),
        .din  (load_hr),
        .q    (hours),
        .wrap (hr_wrap)
    );

    // hr_en is only raised when neither load nor mode is active, so the
    // hours counter never sees en and ld together.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        presc_d = presc_q;
        hr_en   = 1'b0;
        if (load) begin
            min_d   = (load_min > MIN_MAX) ? '0 : load_min;
            state_d = RUN;
            presc_d = '0;
        end else if (mode) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: begin
                    state_d = RUN;
                    presc_d = '0;
                end
                default: state_d = RUN;
            endcase
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        if (presc_q == PRESC_MAX) begin
                            presc_d = '0;
                            if (min_q == MIN_MAX) begin
                                min_d = '0;
                                hr_en = 1'b1;
                            end else begin
                                min_d = min_q + 6'd1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                SET_HR:  hr_en = inc;
                SET_MIN: begin
                    if (inc) begin
                        min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Kept apart from the main block so the hours-wrap feedback does not
    // loop back into the process that produces hr_en.
    always_comb begin
        pm_d = pm_q;
        if (load) begin
            pm_d = load_pm;
        end else if (hr_wrap) begin
            pm_d = ~pm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            min_q   <= '0;
            presc_q <= '0;
            pm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            presc_q <= presc_d;
            pm_q    <= pm_d;
        end
    end

    assign minutes = min_q;
    assign pm      = pm_q;
    assign state   = state_q;

endmodule

// File: tb/tb_clk12_set_ctrl.sv
// Randomised and directed bench for clk12_set_ctrl, checked against a
// minutes-of-day reference model.
module tb_clk12_set_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       mode = 1'b0;
    logic       inc = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_hr = '0;
    logic [5:0] load_min = '0;
    logic       load_pm = 1'b0;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic       pm;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: time as minutes since midnight, plus set-mode index
    // and ticks accumulated towards the next minute.
    int m_total = 0;
    int m_st    = 0;
    int m_pre   = 0;

    clk12_set_ctrl #(.TICKS_PER_MIN(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .mode     (mode),
        .inc      (inc),
        .load     (load),
        .load_hr  (load_hr),
        .load_min (load_min),
        .load_pm  (load_pm),
        .hours    (hours),
        .minutes  (minutes),
        .pm       (pm),
        .state    (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [12:0] exp_vec();
        logic [3:0] h;
        logic [5:0] m;
        logic       p;
        logic [1:0] s;
        h = 4'((m_total % 720) / 60);
        m = 6'(m_total % 60);
        p = (m_total >= 720);
        s = 2'(m_st);
        return {h, m, p, s};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {hours, minutes, pm, state};
    endfunction

    task automatic model_edge(input logic r, l, md, i, t,
                              input logic [3:0] lh, input logic [5:0] lm, input logic lp);
        int h, mm, cur_m;
        if (r) begin
            m_total = 0; m_st = 0; m_pre = 0;
        end else if (l) begin
            h  = (lh > 11) ? 0 : int'(lh);
            mm = (lm > 59) ? 0 : int'(lm);
            m_total = (lp ? 720 : 0) + h * 60 + mm;
            m_st = 0; m_pre = 0;
        end else if (md) begin
            if (m_st == 2) m_pre = 0;
            m_st = (m_st + 1) % 3;
        end else begin
            case (m_st)
                0: if (t) begin
                    m_pre++;
                    if (m_pre == T) begin
                        m_pre = 0;
                        m_total = (m_total + 1) % 1440;
                    end
                end
                1: if (i) m_total = (m_total + 60) % 1440;
                default: if (i) begin
                    cur_m = m_total % 60;
                    m_total = m_total - cur_m + (cur_m + 1) % 60;
                end
            endcase
        end
    endtask

    // Apply one cycle of stimulus; outputs are then stable for sampling.
    task automatic step(input logic r, l, md, i, t,
                        input logic [3:0] lh, input logic [5:0] lm, input logic lp);
        rst = r; load = l; mode = md; inc = i; tick = t;
        load_hr = lh; load_min = lm; load_pm = lp;
        @(posedge clk);
        model_edge(r, l, md, i, t, lh, lm, lp);
        #1;
        rst = 0; load = 0; mode = 0; inc = 0; tick = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset: got %h expected %h", dut_vec(), 13'd0);
        end
    endtask

    task automatic test_run();
        for (int k = 0; k < T; k++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL run_tick%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({hours, minutes, pm, state} !== {4'd0, 6'd1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL run_one_minute: got %0d:%0d pm=%0d st=%0d expected 0:1 pm=0 st=0",
                     hours, minutes, pm, state);
        end
    endtask

    task automatic test_cascade();
        step(0, 1, 0, 0, 0, 4'd11, 6'd59, 0);
        for (int k = 0; k < T; k++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL cascade_tick%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({hours, minutes, pm} !== {4'd0, 6'd0, 1'b1}) begin
            errors++;
            $display("FAIL cascade_final: got %0d:%0d pm=%0d expected 0:0 pm=1", hours, minutes, pm);
        end
    endtask

    task automatic test_set_hours();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL set_hr_enter: got state %0d expected 1", state);
        end
        for (int k = 0; k < 13; k++) step(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_hr_13inc: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        if ({hours, pm} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL set_hr_value: got h=%0d pm=%0d expected h=1 pm=0", hours, pm);
        end
        for (int k = 0; k < 2 * T; k++) step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_hr_tick_ignored: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_set_minutes();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 61; k++) step(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_min_61inc: got %h expected %h", dut_vec(), exp_vec());
        end
        step(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL set_min_exit: got state %0d expected 0", state);
        end
        for (int k = 0; k < T; k++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL presc_clear_tick%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mode_plus_inc: got %h expected %h", dut_vec(), exp_vec());
        end
        step(0, 1, 1, 0, 1, 4'd5, 6'd30, 1);
        checks++;
        if ({hours, minutes, pm, state} !== {4'd5, 6'd30, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL load_with_mode_tick: got %0d:%0d pm=%0d st=%0d expected 5:30 pm=1 st=0",
                     hours, minutes, pm, state);
        end
        step(0, 1, 0, 0, 0, 4'd14, 6'd63, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL load_out_of_range: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_set();
        step(0, 1, 0, 0, 0, 4'd7, 6'd45, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (dut_vec() !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_set: got %h expected %h", dut_vec(), 13'd0);
        end
        for (int k = 0; k < T; k++) step(0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_then_run: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic r, l, md, i, t, lp;
        logic [3:0] lh;
        logic [5:0] lm;
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 299) == 0);
            l  = ($urandom_range(0, 59) == 0);
            md = ($urandom_range(0, 9) == 0);
            i  = $urandom_range(0, 1) == 1;
            t  = $urandom_range(0, 1) == 1;
            lh = 4'($urandom_range(0, 15));
            lm = 6'($urandom_range(0, 63));
            lp = $urandom_range(0, 1) == 1;
            step(r, l, md, i, t, lh, lm, lp);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_cascade();
        test_set_hours();
        test_set_minutes();
        test_simultaneous();
        test_reset_mid_set();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
